// File: rtl/jtvigil_pal_loader.sv
// -----------------------------------------------------------------------------
// jtvigil_pal_loader
//
// Write-side engine for the Vigilante palette RAM (2048 bytes). Each 15-bit
// colour is spread over three bytes at {idx, sub}, where sub 0/1/2 hold R/G/B
// and sub 3 is left alone. A bulk-clear mode fills all 2048 bytes with CLR_VAL.
//
// Parameters:
//   CLR_VAL    byte written to every location in clear mode
//
// Ports:
//   clk        in   core clock
//   rst_n      in   synchronous active-low reset
//   start_clr  in   request a full-RAM clear (sampled only in IDLE)
//   col_valid  in   colour word available
//   col_ready  out  loader accepts a colour this cycle
//   col_idx    in   [8:0]  colour index {sel, pal_base[7:0]}
//   col_rgb    in   [14:0] {R[4:0], G[4:0], B[4:0]}
//   pal_addr   out  [10:0] palette RAM address (registered)
//   pal_dout   out  [7:0]  palette RAM write data (registered)
//   pal_we     out  palette RAM write strobe (registered)
//   busy       out  high in any state other than IDLE
//   done       out  one-cycle pulse with the last write of an operation
// -----------------------------------------------------------------------------
module jtvigil_pal_loader #(
  parameter logic [7:0] CLR_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_clr,
  input  logic        col_valid,
  output logic        col_ready,
  input  logic [8:0]  col_idx,
  input  logic [14:0] col_rgb,
  output logic [10:0] pal_addr,
  output logic [7:0]  pal_dout,
  output logic        pal_we,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_R = 3'd1,
    WR_G = 3'd2,
    WR_B = 3'd3,
    CLR  = 3'd4
  } state_t;

  localparam logic [10:0] CNT_LAST = 11'h7FF;

  state_t      state_q;
  logic [10:0] cnt_q;
  logic [10:0] cnt_d;
  logic [8:0]  idx_q;
  logic [14:0] rgb_q;
  logic [10:0] pal_addr_q;
  logic [7:0]  pal_dout_q;
  logic        pal_we_q;
  logic        done_q;

  // Clear counter advance; the 11-bit wrap is never reached because the
  // terminal test is on 2047 itself.
  assign cnt_d = cnt_q + 11'd1;

  // Clear has priority over a colour presented in the same IDLE cycle.
  assign col_ready = (state_q == IDLE) && !start_clr;
  assign busy      = (state_q != IDLE);

  assign pal_addr  = pal_addr_q;
  assign pal_dout  = pal_dout_q;
  assign pal_we    = pal_we_q;
  assign done      = done_q;

  // Loader FSM. Write outputs are registered on the same edge that enters the
  // state they belong to, so the R write is on the bus in the first cycle of
  // WR_R and the first clear write in the first cycle of CLR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 11'd0;
      idx_q      <= 9'd0;
      rgb_q      <= 15'd0;
      pal_addr_q <= 11'd0;
      pal_dout_q <= 8'd0;
      pal_we_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_clr) begin
            state_q    <= CLR;
            cnt_q      <= 11'd0;
            pal_addr_q <= 11'd0;
            pal_dout_q <= CLR_VAL;
            pal_we_q   <= 1'b1;
            done_q     <= 1'b0;
          end else if (col_valid) begin
            state_q    <= WR_R;
            idx_q      <= col_idx;
            rgb_q      <= col_rgb;
            pal_addr_q <= {col_idx, 2'd0};
            pal_dout_q <= {3'b000, col_rgb[14:10]};
            pal_we_q   <= 1'b1;
            done_q     <= 1'b0;
          end else begin
            pal_we_q   <= 1'b0;
            done_q     <= 1'b0;
          end
        end
        WR_R: begin
          state_q    <= WR_G;
          pal_addr_q <= {idx_q, 2'd1};
          pal_dout_q <= {3'b000, rgb_q[9:5]};
          pal_we_q   <= 1'b1;
          done_q     <= 1'b0;
        end
        WR_G: begin
          state_q    <= WR_B;
          pal_addr_q <= {idx_q, 2'd2};
          pal_dout_q <= {3'b000, rgb_q[4:0]};
          pal_we_q   <= 1'b1;
          done_q     <= 1'b1;
        end
        WR_B: begin
          state_q  <= IDLE;
          pal_we_q <= 1'b0;
          done_q   <= 1'b0;
        end
        CLR: begin
          if (cnt_q == CNT_LAST) begin
            state_q  <= IDLE;
            pal_we_q <= 1'b0;
            done_q   <= 1'b0;
          end else begin
            cnt_q      <= cnt_d;
            pal_addr_q <= cnt_d;
            pal_dout_q <= CLR_VAL;
            pal_we_q   <= 1'b1;
            done_q     <= (cnt_d == CNT_LAST);
          end
        end
        default: begin
          state_q  <= IDLE;
          pal_we_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/jtvigil_pal_loader.md
# jtvigil_pal_loader

Write-side engine for the Vigilante palette RAM. It accepts 15-bit colours over a valid/ready handshake and writes them into the 2048-byte palette in the layout the colour mixer scans: R, G and B bytes at sub-addresses 0, 1 and 2. It also provides a bulk-clear mode that fills the whole RAM. It sits beside the CPU port on the palette dual-port RAM and serves boot-time initialisation, debug colour injection and save-state restore.

## Interface
Parameters:
- `CLR_VAL`, 8'h00: byte written to every location in clear mode.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `start_clr`  in  1  request a full-RAM clear; sampled only in IDLE.
- `col_valid`  in  1  colour word available.
- `col_ready`  out  1  loader can accept a colour this cycle.
- `col_idx`  in  9  colour index, {sel, pal_base[7:0]}.
- `col_rgb`  in  15  {R[4:0], G[4:0], B[4:0]}.
- `pal_addr`  out  11  palette RAM address.
- `pal_dout`  out  8  palette RAM write data.
- `pal_we`  out  1  palette RAM write strobe.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse coinciding with the last write of an operation.

## Operation
- States: IDLE, WR_R, WR_G, WR_B, CLR.
- IDLE:
  - `col_ready = !start_clr`, combinational from state.
  - If `start_clr` is high, go to CLR with clear counter = 0. Clear has priority; a colour presented in the same cycle is not accepted.
  - Else if `col_valid & col_ready`, latch `col_idx` and `col_rgb` and go to WR_R.
- WR_R: write {3'b0, R} to {idx, 2'd0}, then WR_G.
- WR_G: write {3'b0, G} to {idx, 2'd1}, then WR_B.
- WR_B: write {3'b0, B} to {idx, 2'd2}, assert `done`, then IDLE.
  - Sub-address 3 is never written by colour writes.
- CLR:
  - Write `CLR_VAL` to address = counter, one per cycle, counter 0 to 2047, including sub 3.
  - On counter 2047, assert `done` and go to IDLE.
  - The counter is 11 bits; the wrap to 0 is not used as a terminal condition.
- `start_clr` or `col_valid` outside IDLE is ignored and not queued. Upstream must hold `col_valid` until it sees ready.
- Data bits [7:5] are always 0 for colour writes.

## Timing
- `pal_we`, `pal_addr`, `pal_dout` and `done` are registered. `busy` is decoded from the state register.
- Reset values:
  - state IDLE.
  - `pal_we` = 0, `pal_addr` = 0, `pal_dout` = 0, `done` = 0, `busy` = 0.
  - `col_ready` = 1 while `start_clr` = 0.
- Colour accepted at edge N:
  - `pal_we` high with R during cycle N+1, G during N+2, B plus `done` during N+3.
  - `col_ready` is low in cycles N+1 to N+3 and high again in N+4.
  - Throughput: 1 colour per 4 cycles.
- Clear started at edge N: writes occupy cycles N+1 to N+2048, with `done` in N+2048. `busy` is high for exactly 2048 cycles.
- `rst_n` low mid-operation: on the next edge, return to IDLE, drop `pal_we` and `done`, and discard the latched colour. Partial writes already made stay in the RAM.
- `pal_we` is low in every IDLE cycle.

## Test plan
- Reset:
  - Hold `rst_n`=0 for 3 cycles with `col_valid`=1 -> `pal_we`=0, `busy`=0, `done`=0 throughout.
  - First release cycle -> `col_ready`=1.
- Single colour: idx=9'h1A5, rgb={5'h1F,5'h0A,5'h03} -> writes 0x1F@0x694, 0x0A@0x695, 0x03@0x696 on consecutive cycles, `done` with the last write, nothing written to 0x697.
- Back-to-back: `col_valid` held high with two colours -> second accepted exactly 4 cycles after the first, 6 writes total, no gaps other than the IDLE cycle.
- Clear: CLR_VAL=8'h55, pulse `start_clr` -> 2048 writes to addresses 0..2047 ascending, all 0x55, `done` at address 2047, `busy` high 2048 cycles.
- Simultaneous: `start_clr`=1 and `col_valid`=1 in IDLE -> `col_ready`=0, clear runs, and the colour is accepted in the first IDLE cycle after clear if still valid.
- Reset mid-clear: drop `rst_n` after 100 clear writes -> next cycle `pal_we`=0 and state IDLE, and a new colour is accepted immediately after release.
